// File: rtl/impulse_counter_pkg.sv
// Shared types and helpers for the multi-channel impulse counter.
package impulse_counter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT
    } fsm_state_t;

    // One field per channel: sticky overflow bit followed by the count.
    function automatic int frame_len(input int n_ch, input int cnt_w);
        return n_ch * (cnt_w + 1);
    endfunction

endpackage

// File: rtl/impulse_counter_array_channel.sv
// One impulse channel: synchroniser, rising-edge detect, gated counter and sticky overflow.
module pulse_counter_channel #(
    parameter int CNT_W    = 12,
    parameter bit SATURATE = 1'b1,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             win_end,
    input  logic             in,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;
    logic                edge_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], in};
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    assign edge_det = sync_q[SYNC_STG-1] & ~prev_q;

    // An edge landing in the window-end cycle belongs to the new window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (win_end) begin
            cnt <= edge_det ? CNT_W'(1) : '0;
            ovf <= 1'b0;
        end else if (edge_det) begin
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
                cnt <= SATURATE ? CNT_MAX : '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/impulse_counter_array.sv
// Multi-channel impulse counter: RTC gate window, snapshot shadow and paced serial frame output.
//
// state | meaning
// IDLE  | no frame in flight; a window end takes a snapshot
// LOAD  | one cycle: shadow copied into the shift register
// SHIFT | frame on ser_out, one bit per ser_en strobe
module impulse_counter_array
    import impulse_counter_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int CNT_W     = 12,
    parameter int WIN_TICKS = 60,
    parameter bit SATURATE  = 1'b1,
    parameter int SYNC_STG  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_CH-1:0]                    ch_in,
    input  logic                               rtc_tick,
    input  logic                               clr,
    input  logic                               ser_en,
    output logic                               ser_out,
    output logic                               ser_frame,
    output logic                               frame_done,
    output logic                               ovf_any,
    output logic                               overrun,
    output logic [$clog2(WIN_TICKS+1)-1:0]     tick_cnt
);

    localparam int TICK_W    = $clog2(WIN_TICKS + 1);
    localparam int FLD_W     = CNT_W + 1;
    localparam int FRAME_LEN = frame_len(N_CH, CNT_W);
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WIN_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);

    logic [SYNC_STG-1:0]  rtc_sync_q;
    logic                 rtc_prev_q;
    logic                 tick_edge;
    logic                 win_end;
    logic                 snap_take;

    logic [CNT_W-1:0]     live_cnt [N_CH];
    logic [N_CH-1:0]      live_ovf;
    logic [FRAME_LEN-1:0] snap_vec;
    logic [FRAME_LEN-1:0] shadow_q;
    logic [FRAME_LEN-1:0] shreg_q;
    logic [IDX_W-1:0]     bit_idx;
    fsm_state_t           state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtc_sync_q <= '0;
            rtc_prev_q <= 1'b0;
        end else begin
            rtc_sync_q <= {rtc_sync_q[SYNC_STG-2:0], rtc_tick};
            rtc_prev_q <= rtc_sync_q[SYNC_STG-1];
        end
    end

    assign tick_edge = rtc_sync_q[SYNC_STG-1] & ~rtc_prev_q;
    assign win_end   = tick_edge & (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (tick_edge) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pulse_counter_channel #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE),
            .SYNC_STG (SYNC_STG)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr),
            .win_end (win_end),
            .in      (ch_in[g]),
            .cnt     (live_cnt[g]),
            .ovf     (live_ovf[g])
        );
    end

    assign ovf_any = |live_ovf;

    // Channel 0 occupies the top field so it leaves the shift register first.
    always_comb begin
        snap_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            snap_vec[FRAME_LEN-1-i*FLD_W -: FLD_W] = {live_ovf[i], live_cnt[i]};
        end
    end

    assign snap_take = win_end & ~clr & (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (snap_take) begin
            shadow_q <= snap_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (clr) begin
            overrun <= 1'b0;
        end else if (win_end && state != IDLE) begin
            overrun <= 1'b1;
        end
    end

    // The shift register drains to zero, so ser_out idles low between frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg_q    <= '0;
            bit_idx    <= '0;
            ser_frame  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (snap_take) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q   <= shadow_q;
                    bit_idx   <= '0;
                    ser_frame <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (ser_en) begin
                        shreg_q <= {shreg_q[FRAME_LEN-2:0], 1'b0};
                        if (bit_idx == IDX_LAST) begin
                            ser_frame  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ser_out = shreg_q[FRAME_LEN-1];

endmodule

// File: tb/tb_impulse_counter_array.sv
// Directed bench for impulse_counter_array: one 8x12 instance plus two 2x4 instances (saturate / wrap).
module tb_impulse_counter_array;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rtc_tick = 1'b0;
    logic       clr = 1'b0;
    logic       ser_en = 1'b0;
    logic [7:0] ch_in = '0;
    logic [1:0] s_ch_in = '0;

    logic       m_out, m_frame, m_done, m_ovf, m_ovr;
    logic [1:0] m_tick;
    logic       sa_out, sa_frame, sa_done, sa_ovf, sa_ovr;
    logic [1:0] sa_tick;
    logic       sw_out, sw_frame, sw_done, sw_ovf, sw_ovr;
    logic [1:0] sw_tick;

    int n_checks = 0;
    int n_errs   = 0;

    logic [103:0] m_bits = '0;
    logic [9:0]   sa_bits = '0;
    logic [9:0]   sw_bits = '0;
    int           m_nbits = 0, m_dones = 0, m_frames = 0, sa_dones = 0, sw_dones = 0;
    logic         m_frame_d = 1'b0;

    impulse_counter_array #(
        .N_CH(8), .CNT_W(12), .WIN_TICKS(3), .SATURATE(1'b1), .SYNC_STG(2)
    ) dut (
        .clk(clk), .reset(reset), .ch_in(ch_in), .rtc_tick(rtc_tick), .clr(clr),
        .ser_en(ser_en), .ser_out(m_out), .ser_frame(m_frame), .frame_done(m_done),
        .ovf_any(m_ovf), .overrun(m_ovr), .tick_cnt(m_tick)
    );

    impulse_counter_array #(
        .N_CH(2), .CNT_W(4), .WIN_TICKS(3), .SATURATE(1'b1), .SYNC_STG(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .ch_in(s_ch_in), .rtc_tick(rtc_tick), .clr(clr),
        .ser_en(ser_en), .ser_out(sa_out), .ser_frame(sa_frame), .frame_done(sa_done),
        .ovf_any(sa_ovf), .overrun(sa_ovr), .tick_cnt(sa_tick)
    );

    impulse_counter_array #(
        .N_CH(2), .CNT_W(4), .WIN_TICKS(3), .SATURATE(1'b0), .SYNC_STG(2)
    ) dut_wrap (
        .clk(clk), .reset(reset), .ch_in(s_ch_in), .rtc_tick(rtc_tick), .clr(clr),
        .ser_en(ser_en), .ser_out(sw_out), .ser_frame(sw_frame), .frame_done(sw_done),
        .ovf_any(sw_ovf), .overrun(sw_ovr), .tick_cnt(sw_tick)
    );

    always #5 clk = ~clk;

    // A bit is taken at the negedge before the posedge that consumes it.
    always @(negedge clk) begin
        if (m_frame && ser_en) begin
            m_bits = {m_bits[102:0], m_out};
            m_nbits++;
        end
        if (sa_frame && ser_en) sa_bits = {sa_bits[8:0], sa_out};
        if (sw_frame && ser_en) sw_bits = {sw_bits[8:0], sw_out};
        if (m_done)  m_dones++;
        if (sa_done) sa_dones++;
        if (sw_done) sw_dones++;
        if (m_frame && !m_frame_d) m_frames++;
        m_frame_d = m_frame;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] m, input logic [1:0] s, input int n);
        repeat (n) begin
            ch_in = m; s_ch_in = s;
            step(); step();
            ch_in = '0; s_ch_in = '0;
            step(); step();
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            rtc_tick = 1'b1;
            step(); step();
            rtc_tick = 1'b0;
            step(); step();
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int  start;
        bit  seen;
        start = m_dones;
        seen  = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (m_dones != start) seen = 1'b1;
        end
        chk(tag, 128'(seen), 128'(1));
    endtask

    function automatic logic [103:0] fld(input int ch, input logic [12:0] v);
        logic [103:0] r;
        r = '0;
        r[103 - ch*13 -: 13] = v;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb0, d0, sa0, sw0, f0;

        #2;
        chk("rst_ser_frame", 128'(m_frame), 128'(0));
        chk("rst_ser_out",   128'(m_out),   128'(0));
        chk("rst_tick_cnt",  128'(m_tick),  128'(0));
        chk("rst_overrun",   128'(m_ovr),   128'(0));
        step(); step();
        reset = 1'b0;
        step();

        // Counts on two channels, saturation and wrap on the small instances.
        ser_en = 1'b1;
        nb0 = m_nbits; d0 = m_dones; sa0 = sa_dones; sw0 = sw_dones;
        for (int i = 0; i < 20; i++) begin
            pulse({(i < 9), 6'b000000, (i < 5)}, 2'b01, 1);
        end
        step(); step();
        chk("t2_ovf_any_main", 128'(m_ovf),  128'(0));
        chk("t3_ovf_any_sat",  128'(sa_ovf), 128'(1));
        chk("t3_ovf_any_wrap", 128'(sw_ovf), 128'(1));
        tick(1);
        chk("t2_tick_cnt_1", 128'(m_tick), 128'(1));
        tick(2);
        wait_done("t2_frame_done", 300);
        chk("t2_ser_frame_low", 128'(m_frame), 128'(0));
        step(); step(); step();
        chk("t2_frame",      128'(m_bits), 128'(fld(0, 13'h0005) | fld(7, 13'h0009)));
        chk("t2_frame_len",  128'(m_nbits - nb0), 128'(104));
        chk("t2_done_pulses", 128'(m_dones - d0), 128'(1));
        chk("t3_sat_frame",  128'(sa_bits), 128'(10'b11111_00000));
        chk("t3_wrap_frame", 128'(sw_bits), 128'(10'b10100_00000));
        chk("t3_sat_done",   128'(sa_dones - sa0), 128'(1));
        chk("t3_wrap_done",  128'(sw_dones - sw0), 128'(1));
        chk("t3_sat_tick",   128'(sa_tick), 128'(0));
        chk("t3_wrap_ovr",   128'(sw_ovr),  128'(0));
        chk("t3_sat_ovf_clr", 128'(sa_ovf), 128'(0));

        // Channel edge in the window-end cycle moves into the next window.
        tick(2);
        chk("t4_tick_cnt_2", 128'(m_tick), 128'(2));
        ch_in = 8'h08; rtc_tick = 1'b1;
        step(); step();
        ch_in = '0; rtc_tick = 1'b0;
        step(); step();
        wait_done("t4_done_a", 300);
        chk("t4_frame_a", 128'(m_bits), 128'(0));
        tick(3);
        wait_done("t4_done_b", 300);
        chk("t4_frame_b", 128'(m_bits), 128'(fld(3, 13'h0001)));

        // Stall the frame so the next window end overruns.
        ser_en = 1'b0;
        pulse(8'h02, 2'b00, 2);
        tick(3);
        step(); step(); step();
        chk("t5_stalled_frame", 128'(m_frame), 128'(1));
        chk("t5_no_overrun",    128'(m_ovr),   128'(0));
        pulse(8'h02, 2'b00, 4);
        tick(3);
        chk("t5_overrun", 128'(m_ovr), 128'(1));
        pulse(8'h02, 2'b00, 1);
        ser_en = 1'b1;
        wait_done("t5_done_a", 300);
        chk("t5_frame_a",       128'(m_bits), 128'(fld(1, 13'h0002)));
        chk("t5_overrun_stays", 128'(m_ovr),  128'(1));
        tick(3);
        wait_done("t5_done_b", 300);
        chk("t5_frame_b", 128'(m_bits), 128'(fld(1, 13'h0001)));

        // clr coinciding with the window end wins.
        pulse(8'h04, 2'b00, 2);
        tick(2);
        f0 = m_frames;
        rtc_tick = 1'b1;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0; rtc_tick = 1'b0;
        step(); step();
        repeat (20) step();
        chk("t6_no_frame",   128'(m_frames - f0), 128'(0));
        chk("t6_tick_cnt",   128'(m_tick),        128'(0));
        chk("t6_overrun_clr", 128'(m_ovr),        128'(0));
        tick(3);
        wait_done("t6_done", 300);
        chk("t6_frame", 128'(m_bits), 128'(0));

        // Reset in the middle of a frame.
        ser_en = 1'b0;
        pulse(8'h01, 2'b00, 3);
        tick(3);
        step(); step();
        chk("t1_in_frame", 128'(m_frame), 128'(1));
        ser_en = 1'b1;
        repeat (11) step();
        ser_en = 1'b0;
        chk("t1_bit11", 128'(m_out), 128'(1));
        pulse(8'h01, 2'b00, 3);
        tick(1);
        chk("t1_tick_pre", 128'(m_tick), 128'(1));
        reset = 1'b1;
        #1;
        chk("t1_ser_frame", 128'(m_frame), 128'(0));
        chk("t1_ser_out",   128'(m_out),   128'(0));
        chk("t1_tick_cnt",  128'(m_tick),  128'(0));
        step(); step();
        reset = 1'b0;
        step();
        nb0 = m_nbits;
        ser_en = 1'b1;
        tick(3);
        wait_done("t1_done", 300);
        chk("t1_frame",     128'(m_bits), 128'(0));
        chk("t1_frame_len", 128'(m_nbits - nb0), 128'(104));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
